// File: rtl/aes_pkg.sv
// ============================================================================
// Module   : aes_pkg
// Purpose  : Shared AES-128 constants, FSM state encoding and GF(2^8) helper.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package aes_pkg;

  localparam int AES_NR          = 10;
  localparam int AES_KEY_SCHED_W = 1408;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ROUND = 2'd1,
    ST_DONE  = 2'd2
  } aes_state_e;

  // Multiply by x in GF(2^8), reduced by x^8 + x^4 + x^3 + x + 1.
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

endpackage

`default_nettype wire

// File: rtl/aes_round.sv
// ============================================================================
// Module   : aes_round
// Purpose  : One combinational AES encryption round; MixColumns skipped when
//            final_round is set.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module aes_round
  import aes_pkg::*;
(
  input  logic [127:0] state_in,
  input  logic [127:0] round_key,
  input  logic         final_round,
  output logic [127:0] state_out
);

  logic [7:0] sb [16];
  logic [7:0] sr [16];
  logic [7:0] mc [16];

  for (genvar i = 0; i < 16; i++) begin : g_sbox
    aes_sbox u_sbox (
      .a_i (state_in[127-8*i -: 8]),
      .y_o (sb[i])
    );
  end

  // Byte 4c+r sits at row r, column c; row r rotates left by r columns.
  for (genvar c = 0; c < 4; c++) begin : g_col
    for (genvar r = 0; r < 4; r++) begin : g_row
      assign sr[4*c+r] = sb[4*((c+r)%4)+r];
    end

    assign mc[4*c+0] = xtime(sr[4*c+0]) ^ xtime(sr[4*c+1]) ^ sr[4*c+1] ^ sr[4*c+2] ^ sr[4*c+3];
    assign mc[4*c+1] = sr[4*c+0] ^ xtime(sr[4*c+1]) ^ xtime(sr[4*c+2]) ^ sr[4*c+2] ^ sr[4*c+3];
    assign mc[4*c+2] = sr[4*c+0] ^ sr[4*c+1] ^ xtime(sr[4*c+2]) ^ xtime(sr[4*c+3]) ^ sr[4*c+3];
    assign mc[4*c+3] = xtime(sr[4*c+0]) ^ sr[4*c+0] ^ sr[4*c+1] ^ sr[4*c+2] ^ xtime(sr[4*c+3]);
  end

  for (genvar i = 0; i < 16; i++) begin : g_ark
    assign state_out[127-8*i -: 8] = (final_round ? sr[i] : mc[i]) ^ round_key[127-8*i -: 8];
  end

endmodule

`default_nettype wire

// File: rtl/aes_sbox.sv
// ============================================================================
// Module   : aes_sbox
// Purpose  : Forward AES S-box, single byte lookup.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module aes_sbox (
  input  logic [7:0] a_i,
  output logic [7:0] y_o
);

  localparam logic [7:0] SBOX_TABLE [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  assign y_o = SBOX_TABLE[a_i];

endmodule

`default_nettype wire

// File: rtl/aes_encrypt_core.sv
// ============================================================================
// Module   : aes_encrypt_core
// Purpose  : Iterative AES-128 encryptor, one round per clock, valid/ready I/O.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module aes_encrypt_core
  import aes_pkg::*;
(
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [127:0]               plaintext,
  input  logic [AES_KEY_SCHED_W-1:0] expanded_keys,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [127:0]               ciphertext,
  output logic                       busy
);

  aes_state_e                 fsm_q, fsm_d;
  logic [127:0]               state_q, state_d;
  logic [AES_KEY_SCHED_W-1:0] keys_q, keys_d;
  logic [3:0]                 rnd_q, rnd_d;

  logic [127:0] rk [0:AES_NR];
  logic [127:0] round_out;
  logic         final_round;

  for (genvar g = 0; g <= AES_NR; g++) begin : g_rk
    assign rk[g] = keys_q[AES_KEY_SCHED_W-1-128*g -: 128];
  end

  assign final_round = (rnd_q == 4'(AES_NR));

  aes_round u_round (
    .state_in    (state_q),
    .round_key   (rk[rnd_q]),
    .final_round (final_round),
    .state_out   (round_out)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      fsm_q   <= ST_IDLE;
      state_q <= '0;
      keys_q  <= '0;
      rnd_q   <= 4'd0;
    end else begin
      fsm_q   <= fsm_d;
      state_q <= state_d;
      keys_q  <= keys_d;
      rnd_q   <= rnd_d;
    end
  end

  always_comb begin
    fsm_d   = fsm_q;
    state_d = state_q;
    keys_d  = keys_q;
    rnd_d   = rnd_q;
    case (fsm_q)
      ST_IDLE: begin
        if (in_valid) begin
          state_d = plaintext ^ expanded_keys[AES_KEY_SCHED_W-1 -: 128];
          keys_d  = expanded_keys;
          rnd_d   = 4'd1;
          fsm_d   = ST_ROUND;
        end
      end
      ST_ROUND: begin
        state_d = round_out;
        // Counter parks at the last round so it never wraps.
        if (final_round) begin
          fsm_d = ST_DONE;
        end else begin
          rnd_d = rnd_q + 4'd1;
        end
      end
      ST_DONE: begin
        if (out_ready) begin
          fsm_d = ST_IDLE;
        end
      end
      default: begin
        fsm_d = ST_IDLE;
      end
    endcase
  end

  assign in_ready   = (fsm_q == ST_IDLE);
  assign out_valid  = (fsm_q == ST_DONE);
  assign busy       = (fsm_q == ST_ROUND) || (fsm_q == ST_DONE);
  assign ciphertext = state_q;

endmodule

`default_nettype wire

// File: tb/tb_aes_encrypt_core.sv
// ============================================================================
// Module   : tb_aes_encrypt_core
// Purpose  : Scoreboard bench for aes_encrypt_core against a GF(2^8) model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_aes_encrypt_core;

  logic            clk = 1'b0;
  logic            rst;
  logic            in_valid;
  logic            in_ready;
  logic [127:0]    plaintext;
  logic [1407:0]   expanded_keys;
  logic            out_valid;
  logic            out_ready;
  logic [127:0]    ciphertext;
  logic            busy;

  aes_encrypt_core dut (
    .clk           (clk),
    .rst           (rst),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .plaintext     (plaintext),
    .expanded_keys (expanded_keys),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .ciphertext    (ciphertext),
    .busy          (busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [127:0] ct;
    int           acc;
  } exp_t;
  exp_t sb[$];

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  logic [7:0] sbox_tab [256];

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p = p ^ a;
      a = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
      b = b >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
    return (b << n) | (b >> (8 - n));
  endfunction

  task automatic build_sbox();
    logic [7:0] inv;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h01;
      if (x == 0) inv = 8'h00;
      else for (int k = 0; k < 254; k++) inv = gmul(inv, 8'(x));
      sbox_tab[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
  endtask

  function automatic logic [1407:0] key_expand(input logic [127:0] key);
    logic [31:0]   w [44];
    logic [31:0]   t;
    logic [7:0]    rcon;
    logic [1407:0] ks;
    rcon = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sbox_tab[t[31:24]], sbox_tab[t[23:16]], sbox_tab[t[15:8]], sbox_tab[t[7:0]]} ^ {rcon, 24'h0};
        rcon = gmul(rcon, 8'h02);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int i = 0; i < 44; i++) ks[1407-32*i -: 32] = w[i];
    return ks;
  endfunction

  function automatic logic [127:0] enc_model(input logic [127:0] pt, input logic [1407:0] ks);
    logic [7:0]   s [16];
    logic [7:0]   t [16];
    logic [7:0]   coef [4];
    logic [7:0]   acc;
    logic [127:0] res;
    coef = '{8'h02, 8'h03, 8'h01, 8'h01};
    for (int i = 0; i < 16; i++) s[i] = pt[127-8*i -: 8] ^ ks[1407-8*i -: 8];
    for (int r = 1; r <= 10; r++) begin
      for (int i = 0; i < 16; i++) s[i] = sbox_tab[s[i]];
      for (int c = 0; c < 4; c++)
        for (int row = 0; row < 4; row++) t[4*c+row] = s[4*((c+row)%4)+row];
      s = t;
      if (r < 10) begin
        for (int c = 0; c < 4; c++)
          for (int row = 0; row < 4; row++) begin
            acc = 8'h00;
            for (int k = 0; k < 4; k++) acc = acc ^ gmul(coef[(k-row+4)%4], s[4*c+k]);
            t[4*c+row] = acc;
          end
        s = t;
      end
      for (int i = 0; i < 16; i++) s[i] = s[i] ^ ks[1407-128*r-8*i -: 8];
    end
    for (int i = 0; i < 16; i++) res[127-8*i -: 8] = s[i];
    return res;
  endfunction

  // ---------------- monitor ----------------
  logic         prev_valid = 1'b0;
  logic [127:0] prev_ct    = '0;

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_valid = 1'b0;
      end else begin
        if (out_valid && !prev_valid) begin
          if (sb.size() == 0) chk("unexpected_out_valid", 128'(out_valid), 128'(0));
          else chk("latency", 128'(cyc - sb[0].acc), 128'(10));
        end
        if (out_valid && prev_valid) chk("ct_stable", ciphertext, prev_ct);
        if (out_valid && out_ready && sb.size() != 0) begin
          e = sb.pop_front();
          chk("ciphertext", ciphertext, e.ct);
        end
        prev_valid = out_valid && !out_ready;
        prev_ct    = ciphertext;
      end
    end
  end

  // ---------------- stimulus ----------------
  localparam logic [127:0] KEY_B = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] PT_B  = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] CT_B  = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] KEY_C = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] PT_C  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CT_C  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

  task automatic issue(input logic [127:0] key, input logic [127:0] pt, input bit push,
                       input logic [127:0] exp, output int acc);
    int n;
    @(negedge clk);
    plaintext     = pt;
    expanded_keys = key_expand(key);
    in_valid      = 1'b1;
    n = 0;
    while (!in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) chk("accept_timeout", 128'(in_ready), 128'(1));
    acc = cyc + 1;
    if (push) sb.push_back('{exp, acc});
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle(input bit rand_bp);
    int n;
    n = 0;
    while (sb.size() != 0 && n < 300) begin
      if (rand_bp) out_ready = 1'($urandom_range(0, 1));
      @(posedge clk);
      #1;
      n++;
    end
    out_ready = 1'b1;
    if (sb.size() != 0) begin
      chk("drain_timeout", 128'(sb.size()), 128'(0));
      sb.delete();
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    int a1, a2, n;
    logic [127:0] k, p;
    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b1;
    plaintext = '0;
    expanded_keys = '0;
    build_sbox();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready", 128'(in_ready), 128'(1));
    chk("rst_out_valid", 128'(out_valid), 128'(0));
    chk("rst_busy", 128'(busy), 128'(0));
    chk("rst_ct", ciphertext, 128'h0);
    rst = 1'b0;

    // FIPS-197 vectors
    issue(KEY_B, PT_B, 1'b1, CT_B, a1);
    in_valid = 1'b0;
    chk("busy_in_round", 128'(busy), 128'(1));
    wait_idle(1'b0);
    issue(KEY_C, PT_C, 1'b1, CT_C, a1);
    in_valid = 1'b0;
    wait_idle(1'b0);

    // Backpressure in DONE
    out_ready = 1'b0;
    issue(KEY_B, PT_B, 1'b1, CT_B, a1);
    in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("bp_reached_done", 128'(out_valid), 128'(1));
    repeat (5) begin
      @(negedge clk);
      chk("bp_in_ready_low", 128'(in_ready), 128'(0));
      chk("bp_out_valid_held", 128'(out_valid), 128'(1));
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("bp_idle_in_ready", 128'(in_ready), 128'(1));
    chk("bp_idle_out_valid", 128'(out_valid), 128'(0));

    // Input isolation
    issue(KEY_B, PT_B, 1'b1, CT_B, a1);
    in_valid      = 1'b0;
    plaintext     = '1;
    expanded_keys = '1;
    wait_idle(1'b0);

    // Reset during round 5, then a fresh run
    issue(KEY_C, PT_C, 1'b0, CT_C, a1);
    in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("midrst_in_ready", 128'(in_ready), 128'(1));
    chk("midrst_out_valid", 128'(out_valid), 128'(0));
    chk("midrst_busy", 128'(busy), 128'(0));
    chk("midrst_ct", ciphertext, 128'h0);
    rst = 1'b0;
    repeat (15) @(posedge clk);
    #1;
    issue(KEY_C, PT_C, 1'b1, CT_C, a1);
    in_valid = 1'b0;
    wait_idle(1'b0);

    // Back-to-back with in_valid held high
    out_ready = 1'b1;
    issue(KEY_B, PT_B, 1'b1, CT_B, a1);
    issue(KEY_C, PT_C, 1'b1, CT_C, a2);
    in_valid = 1'b0;
    chk("b2b_spacing", 128'(a2 - a1), 128'(12));
    wait_idle(1'b0);

    // Random vectors with random backpressure
    for (int v = 0; v < 8; v++) begin
      k = {$urandom, $urandom, $urandom, $urandom};
      p = {$urandom, $urandom, $urandom, $urandom};
      issue(k, p, 1'b1, enc_model(p, key_expand(k)), a1);
      in_valid = 1'b0;
      wait_idle(1'b1);
    end

    chk("scoreboard_empty", 128'(sb.size()), 128'(0));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/aes_encrypt_core.md
AES_ENCRYPT_CORE -- requirements
Module: aes_encrypt_core

Interface
REQ-001 Parameters: none; the block is fixed at AES-128 with 10 rounds.
REQ-002 clk  input  1  Single clock; all state changes on the rising edge.
REQ-003 rst  input  1  Synchronous, active-high reset.
REQ-004 in_valid  input  1  Plaintext and key schedule are presented.
REQ-005 in_ready  output  1  Core can accept a block.
REQ-006 plaintext  input  128  Byte 0 is bits [127:120]; column-major FIPS-197 state order.
REQ-007 expanded_keys  input  1408  44-word schedule from aes_key_expansion; round key r is bits [1407-128r -: 128].
REQ-008 out_valid  output  1  Ciphertext is valid.
REQ-009 out_ready  input  1  Downstream accepts the ciphertext.
REQ-010 ciphertext  output  128  Result, in the same byte order as plaintext.
REQ-011 busy  output  1  High in ROUND and DONE.

Function
REQ-012 FSM states: IDLE, ROUND, DONE.
REQ-013 in_ready SHALL be 1 only in IDLE; out_valid SHALL be 1 only in DONE.
REQ-014 Accept is in_valid && in_ready, in IDLE only. On accept:
- state_reg <= plaintext ^ round key 0
- all 1408 key bits latched internally
- round counter <= 1
- go to ROUND
REQ-015 Input changes after accept SHALL NOT affect the result.
REQ-016 In ROUND, each cycle applies round r to state_reg:
- rounds 1..9: SubBytes, ShiftRows, MixColumns, AddRoundKey(r)
- round 10: no MixColumns
- then counter r increments.
REQ-017 After round 10 is applied, the FSM SHALL go to DONE; out_valid SHALL rise exactly 10 cycles after the accept edge.
REQ-018 In DONE, ciphertext SHALL hold stable until out_valid && out_ready, then the FSM returns to IDLE on the next edge.
REQ-019 out_ready held high SHALL give 12 cycles per block: accept, 10 rounds, 1 DONE cycle.
REQ-020 in_valid in ROUND or DONE SHALL be ignored; no queueing.
REQ-021 out_ready outside DONE has no effect.
REQ-022 Round counter is 4 bits wide, values 1..10; it SHALL never wrap during an operation.
REQ-023 MixColumns SHALL use GF(2^8) xtime with reduction polynomial 0x11b.

Reset
REQ-024 rst SHALL take effect on the next edge from any state, including mid-round:
- FSM -> IDLE
- round counter -> 0
- state_reg, ciphertext -> 128'h0
- out_valid -> 0, busy -> 0, in_ready -> 1 after the edge
- latched keys -> 0
REQ-025 An operation interrupted by reset SHALL produce no output.

Structure
REQ-026 A shared package aes_pkg SHALL hold:
- AES_NR = 10
- AES_KEY_SCHED_W = 1408
- FSM state encoding
- xtime function
REQ-027 Sub-module aes_round (combinational) SHALL take state_in, round_key and final_round, and return state_out.
REQ-028 aes_round SHALL instantiate the existing aes_sbox 16 times; no second S-box table.
REQ-029 Only one aes_round instance is allowed (iterative datapath); the block targets about 200-300 RTL lines including aes_round.

Verification
REQ-030 FIPS-197 App. B: key 2b7e151628aed2a6abf7158809cf4f3c, pt 3243f6a8885a308d313198a2e0370734 -> ct 3925841d02dc09fbdc118597196a0b32, out_valid 10 cycles after accept.
REQ-031 FIPS-197 App. C.1: key 000102030405060708090a0b0c0d0e0f, pt 00112233445566778899aabbccddeeff -> ct 69c4e0d86a7b0430d8cdb78070b4c55a.
REQ-032 Backpressure: hold out_ready=0 for 5 cycles in DONE -> ciphertext stable, in_ready=0 throughout; raise out_ready -> IDLE next edge.
REQ-033 Input isolation: change pt and keys to all-ones on the cycle after accept -> App. B ciphertext is still produced.
REQ-034 Reset mid-operation: assert rst at round 5 -> next edge IDLE, outputs zero; a fresh App. C.1 run then gives the correct ct.
REQ-035 Back-to-back: in_valid held high with two vectors queued, out_ready=1 -> both ciphertexts correct, accepts 12 cycles apart.
